// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: NOP encoding, base opcodes used by decode,
// fetch FSM states and the prefetch buffer entry layout.
package riscv_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DISCARD
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO of {pc, instr} entries. DEPTH must be a power
// of two (2 or 4) so the read/write pointers wrap naturally.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  output fetch_entry_t  head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]            count_q, count_d;

  // Pointer/occupancy update; flush wins over push and pop.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state is reset; storage is not, as it is only read when non-empty.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage register.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: single-outstanding imem request port, prefetch
// FIFO and registered decode-side outputs with stall and redirect/flush.
// Optional macro IFETCH_MISALIGN_TRAP_EN adds the sticky fetch_misaligned
// flag, which blocks new requests while set.
module instruction_fetch
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic [31:0] pipe_pc_out,
  output logic        instr_valid
`ifdef IFETCH_MISALIGN_TRAP_EN
  ,
  output logic        fetch_misaligned
`endif
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   imem_addr_q, imem_addr_d;
  logic [31:0]   instr_q, instr_d;
  logic [31:0]   pc_q, pc_d;
  logic          valid_q, valid_d;

  logic [31:0]   redirect_pc_al;
  logic [31:0]   pc_plus4;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count, count_after;
  fetch_entry_t  fifo_head, push_entry;
  logic          can_issue;
  logic          unused_ok;

  assign redirect_pc_al = {redirect_pc[31:2], 2'b00};
  assign pc_plus4       = fetch_pc_q + 32'd4;
  assign push_entry     = '{pc: fetch_pc_q, instr: imem_rdata};
  assign unused_ok      = ^{redirect_pc[1:0], fifo_full};

`ifdef IFETCH_MISALIGN_TRAP_EN
  logic trap_q, trap_d;

  // Misalignment flag: every redirect re-evaluates it, otherwise it is sticky.
  always_comb begin
    trap_d = trap_q;
    if (redirect) begin
      trap_d = (redirect_pc[1:0] != 2'b00);
    end
  end

  // Misalignment flag register.
  always_ff @(posedge clock) begin
    if (reset) begin
      trap_q <= 1'b0;
    end else begin
      trap_q <= trap_d;
    end
  end

  assign can_issue        = !trap_d;
  assign fetch_misaligned = trap_q;
`else
  assign can_issue = 1'b1;
`endif

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .flush    (redirect),
    .push     (fifo_push),
    .push_data(push_entry),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign fifo_pop = !redirect && !stall && !fifo_empty;

  // Fetch FSM: request issue, ack handling, redirect/discard sequencing.
  // Occupancy plus the single outstanding request never exceeds FIFO_DEPTH,
  // so an ack never lands in a full FIFO.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    imem_addr_d = imem_addr_q;
    fifo_push   = 1'b0;
    count_after = fifo_count - CW'(fifo_pop) + CW'(1);
    unique case (state_q)
      IDLE: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc_al;
          if (can_issue) begin
            state_d     = REQ;
            imem_addr_d = redirect_pc_al;
          end
        end else if (can_issue && (fifo_count < CW'(FIFO_DEPTH))) begin
          state_d     = REQ;
          imem_addr_d = fetch_pc_q;
        end
      end
      REQ: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc_al;
          if (imem_ack) begin
            if (can_issue) begin
              imem_addr_d = redirect_pc_al;
            end else begin
              state_d = IDLE;
            end
          end else begin
            state_d = DISCARD;
          end
        end else if (imem_ack) begin
          fifo_push  = 1'b1;
          fetch_pc_d = pc_plus4;
          if (can_issue && (count_after < CW'(FIFO_DEPTH))) begin
            imem_addr_d = pc_plus4;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DISCARD: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc_al;
        end
        if (imem_ack) begin
          if (can_issue) begin
            state_d     = REQ;
            imem_addr_d = fetch_pc_d;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Decode-side output register: redirect bubble, stall hold, pop or bubble.
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (redirect) begin
      instr_d = NOP;
      pc_d    = '0;
      valid_d = 1'b0;
    end else if (!stall) begin
      if (!fifo_empty) begin
        instr_d = fifo_head.instr;
        pc_d    = fifo_head.pc;
        valid_d = 1'b1;
      end else begin
        instr_d = NOP;
        pc_d    = '0;
        valid_d = 1'b0;
      end
    end
  end

  // State, fetch PC, request address and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC;
      imem_addr_q <= RESET_PC;
      instr_q     <= NOP;
      pc_q        <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      imem_addr_q <= imem_addr_d;
      instr_q     <= instr_d;
      pc_q        <= pc_d;
      valid_q     <= valid_d;
    end
  end

  assign imem_req    = (state_q != IDLE);
  assign imem_addr   = imem_addr_q;
  assign instr_out   = instr_q;
  assign pipe_pc_out = pc_q;
  assign instr_valid = valid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: memory responder, directed
// scenarios, random stall/redirect/ack-delay traffic and a stream scoreboard.
module tb_instruction_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_W    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset, stall, redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr_out, pipe_pc_out;
  logic        instr_valid;
`ifdef IFETCH_MISALIGN_TRAP_EN
  logic        fetch_misaligned;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instruction_fetch #(
    .RESET_PC  (RESET_PC),
    .FIFO_DEPTH(2)
  ) dut (
    .clock      (clk),
    .reset      (reset),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr_out  (instr_out),
    .pipe_pc_out(pipe_pc_out),
    .instr_valid(instr_valid)
`ifdef IFETCH_MISALIGN_TRAP_EN
    ,
    .fetch_misaligned(fetch_misaligned)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0000_00A0 + (a >> 2);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory responder: acks each request after a chosen delay, checks the
  // request stays stable, and optionally fires stray acks while idle.
  int unsigned ack_delay_cfg = 0;
  bit          ack_rand      = 1'b0;
  bit          spurious_en   = 1'b0;
  bit          pend          = 1'b0;
  int unsigned wait_left     = 0;
  logic [31:0] pend_addr     = '0;

  initial begin
    imem_ack   = 1'b0;
    imem_rdata = '0;
  end

  always @(posedge clk) begin
    #2;
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    if (reset) begin
      pend = 1'b0;
    end else if (imem_req) begin
      if (!pend) begin
        pend      = 1'b1;
        pend_addr = imem_addr;
        wait_left = ack_rand ? $urandom_range(0, 3) : ack_delay_cfg;
        chk("req_addr_aligned", {30'd0, imem_addr[1:0]}, 32'd0);
      end else begin
        chk("req_addr_stable", imem_addr, pend_addr);
      end
      if (wait_left == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(pend_addr);
        pend       = 1'b0;
      end else begin
        wait_left--;
      end
    end else begin
      if (pend) begin
        chk("req_withdrawn", 32'd0, 32'd1);
        pend = 1'b0;
      end
      if (spurious_en && ($urandom_range(0, 7) == 0)) begin
        imem_ack   = 1'b1;
        imem_rdata = $urandom;
      end
    end
  end

  // Scoreboard: the driver queues each redirect target as it issues it; the
  // monitor expects consecutive words from each restart point.
  logic [31:0] start_q[$];
  logic [31:0] exp_pc = RESET_PC;
  int          n_valid = 0;
  logic        prev_reset = 1'b1, prev_redirect = 1'b0, prev_stall = 1'b0;
  logic [31:0] prev_instr = '0, prev_pc = '0;
  logic        prev_valid = 1'b0;

  always @(negedge clk) begin
    if (prev_reset) begin
      chk("reset_instr", instr_out, NOP_W);
      chk("reset_pc", pipe_pc_out, 32'd0);
      chk("reset_valid", {31'd0, instr_valid}, 32'd0);
      chk("reset_req", {31'd0, imem_req}, 32'd0);
      chk("reset_addr", imem_addr, RESET_PC);
      exp_pc = RESET_PC;
    end else if (prev_redirect) begin
      chk("redirect_instr", instr_out, NOP_W);
      chk("redirect_pc_out", pipe_pc_out, 32'd0);
      chk("redirect_valid", {31'd0, instr_valid}, 32'd0);
      if (start_q.size() == 0) begin
        chk("redirect_target_queued", 32'd0, 32'd1);
      end else begin
        exp_pc = start_q.pop_front();
      end
    end else if (prev_stall) begin
      chk("stall_hold_instr", instr_out, prev_instr);
      chk("stall_hold_pc", pipe_pc_out, prev_pc);
      chk("stall_hold_valid", {31'd0, instr_valid}, {31'd0, prev_valid});
    end else if (instr_valid) begin
      chk("stream_pc", pipe_pc_out, exp_pc);
      chk("stream_instr", instr_out, mem_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
      n_valid++;
    end else begin
      chk("bubble_instr", instr_out, NOP_W);
      chk("bubble_pc", pipe_pc_out, 32'd0);
    end
    prev_reset    = reset;
    prev_redirect = redirect;
    prev_stall    = stall;
    prev_instr    = instr_out;
    prev_pc       = pipe_pc_out;
    prev_valid    = instr_valid;
  end

  task automatic wait_valid(output logic [31:0] pc, output bit ok);
    ok = 1'b0;
    pc = '0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (instr_valid) begin
        pc = pipe_pc_out;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_redirect(input logic [31:0] target);
    step();
    redirect    = 1'b1;
    redirect_pc = target;
    start_q.push_back({target[31:2], 2'b00});
    step();
    redirect = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          req_cyc, val_cyc, cnt;
    logic [31:0] first_addr, addr_seen, pc_seen;
    bit          found, ok;
    int          n_before;

    reset       = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    repeat (3) step();
    reset = 1'b0;

    // Immediate acks: first-request latency and full throughput.
    req_cyc    = -1;
    val_cyc    = -1;
    first_addr = 32'hFFFF_FFFF;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_req && req_cyc < 0) begin
        req_cyc    = i;
        first_addr = imem_addr;
      end
      if (instr_valid && val_cyc < 0) val_cyc = i;
    end
    chk("first_req_addr", first_addr, RESET_PC);
    chk("first_valid_latency", val_cyc - req_cyc, 32'd2);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (instr_valid) cnt++;
    end
    chk("steady_throughput", cnt, 32'd10);

    // Three-cycle ack latency: one instruction every four cycles.
    ack_delay_cfg = 3;
    repeat (12) @(negedge clk);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (instr_valid) cnt++;
    end
    chk("delay3_valid_count", cnt, 32'd4);

    // Five-cycle stall with immediate acks.
    ack_delay_cfg = 0;
    repeat (10) @(negedge clk);
    step();
    stall = 1'b1;
    repeat (4) step();
    @(negedge clk);
    chk("stall_req_stopped", {31'd0, imem_req}, 32'd0);
    step();
    stall = 1'b0;
    step();
    @(negedge clk);
    chk("post_stall_valid0", {31'd0, instr_valid}, 32'd1);
    step();
    @(negedge clk);
    chk("post_stall_valid1", {31'd0, instr_valid}, 32'd1);

    // Redirect while the request to 0x8 is outstanding.
    ack_delay_cfg = 2;
    step();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (imem_req && imem_addr == 32'h8) begin
        found = 1'b1;
        break;
      end
    end
    chk("saw_req_8", {31'd0, found}, 32'd1);
    do_redirect(32'h0000_0100);
    @(negedge clk);
    chk("redir_edge_nop", instr_out, NOP_W);
    chk("redir_edge_valid", {31'd0, instr_valid}, 32'd0);
    addr_seen = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_req && imem_addr != 32'h8) begin
        addr_seen = imem_addr;
        break;
      end
    end
    chk("redir_next_addr", addr_seen, 32'h0000_0100);
    wait_valid(pc_seen, ok);
    chk("redir_first_valid_seen", {31'd0, ok}, 32'd1);
    chk("redir_first_valid_pc", pc_seen, 32'h0000_0100);

    // Address wrap at the top of the address space.
    ack_delay_cfg = 0;
    do_redirect(32'hFFFF_FFFC);
    wait_valid(pc_seen, ok);
    chk("wrap_first_seen", {31'd0, ok}, 32'd1);
    chk("wrap_first_pc", pc_seen, 32'hFFFF_FFFC);
    wait_valid(pc_seen, ok);
    chk("wrap_second_seen", {31'd0, ok}, 32'd1);
    chk("wrap_second_pc", pc_seen, 32'h0000_0000);

`ifdef IFETCH_MISALIGN_TRAP_EN
    // Misaligned redirect blocks fetching until an aligned redirect.
    do_redirect(32'h0000_0102);
    repeat (3) @(negedge clk);
    chk("misalign_flag_set", {31'd0, fetch_misaligned}, 32'd1);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (imem_req) cnt++;
    end
    chk("misalign_no_req", cnt, 32'd0);
    do_redirect(32'h0000_0200);
    @(negedge clk);
    chk("misalign_flag_clear", {31'd0, fetch_misaligned}, 32'd0);
    wait_valid(pc_seen, ok);
    chk("misalign_resume_pc", pc_seen, 32'h0000_0200);
`endif

    // Random traffic: stalls, redirects, resets, variable and stray acks.
    ack_rand    = 1'b1;
    spurious_en = 1'b1;
    n_before    = n_valid;
    for (int i = 0; i < 2000; i++) begin
      step();
      reset    = ($urandom_range(0, 299) == 0);
      stall    = ($urandom_range(0, 3) == 0);
      redirect = 1'b0;
      if (!reset && ($urandom_range(0, 15) == 0)) begin
        logic [31:0] t;
        t = $urandom;
        if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 | (t & 32'hF);
`ifdef IFETCH_MISALIGN_TRAP_EN
        t[1:0] = 2'b00;
`endif
        redirect    = 1'b1;
        redirect_pc = t;
        start_q.push_back({t[31:2], 2'b00});
      end
    end
    step();
    reset    = 1'b0;
    stall    = 1'b0;
    redirect = 1'b0;
    repeat (20) step();
    chk("random_progress", {31'd0, (n_valid - n_before) > 100}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
